// File: rtl/oam_pkg.sv
// Shared OAM / sprite-slot types for the per-scanline sprite scheduler.
package oam_pkg;

    // OAM entry field positions
    localparam int unsigned OamRefLsb    = 0;
    localparam int unsigned OamXLsb      = 8;
    localparam int unsigned OamYLsb      = 18;
    localparam int unsigned OamPrioBit   = 28;
    localparam int unsigned OamXflipBit  = 29;
    localparam int unsigned OamYflipBit  = 30;
    localparam int unsigned OamEnableBit = 31;

    typedef struct packed {
        logic       enable;
        logic       yflip;
        logic       xflip;
        logic       prio;
        logic [9:0] y;
        logic [9:0] x;
        logic [7:0] spriteref;
    } oam_entry_t;

    typedef struct packed {
        logic       prio;
        logic       xflip;
        logic [3:0] row;
        logic [9:0] x;
        logic [7:0] spriteref;
    } sprite_slot_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFinish
    } eval_state_e;

    // Unpack a raw OAM word into its named fields.
    function automatic oam_entry_t decode_entry(input logic [31:0] raw);
        oam_entry_t e;
        e.spriteref = raw[OamRefLsb +: 8];
        e.x         = raw[OamXLsb +: 10];
        e.y         = raw[OamYLsb +: 10];
        e.prio      = raw[OamPrioBit];
        e.xflip     = raw[OamXflipBit];
        e.yflip     = raw[OamYflipBit];
        e.enable    = raw[OamEnableBit];
        return e;
    endfunction

endpackage

// File: rtl/sprite_slot_bank.sv
// Double-buffered sprite slot storage: back bank written during a scan, front bank
// read by the renderer; a swap strobe flips which bank is front.
module sprite_slot_bank
    import oam_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(Depth)-1:0] wr_idx,
    input  sprite_slot_t             wr_data,
    input  logic                     swap,
    input  logic [$clog2(Depth)-1:0] rd_idx,
    output sprite_slot_t             rd_data
);

    sprite_slot_t mem_q [2][Depth];
    logic         front_q, front_d;

    // Flip the front/back assignment on swap.
    always_comb begin
        front_d = front_q;
        if (swap) begin
            front_d = ~front_q;
        end
    end

    // Bank-select flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_q <= 1'b0;
        end else begin
            front_q <= front_d;
        end
    end

    // Slot storage is deliberately not reset; the count qualifies valid slots.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[~front_q][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[front_q][rd_idx];

endmodule

// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite scheduler: walks OAM once per line_start, collects up to
// MaxPerLine intersecting sprites in OAM order into a double-buffered slot list.
// Optional feature macro: SPRITE_OVERFLOW_EN (full scan + overflow reporting);
// when undefined the scan ends as soon as the list fills and overflow reads 0.
module sprite_line_evaluator
    import oam_pkg::*;
#(
    parameter int unsigned OAMObjects   = 64,
    parameter int unsigned MaxPerLine   = 8,
    parameter int unsigned SpriteHeight = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          line_start,
    input  logic [9:0]                    line_y,
    output logic [$clog2(OAMObjects)-1:0] oam_addr,
    input  logic [31:0]                   oam_data,
    input  logic [$clog2(MaxPerLine)-1:0] slot_sel,
    output logic [23:0]                   slot_data,
    output logic [$clog2(MaxPerLine):0]   slot_count,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int unsigned AddrW = $clog2(OAMObjects);
    localparam int unsigned IdxW  = $clog2(MaxPerLine);
    localparam int unsigned CntW  = IdxW + 1;

    localparam logic [AddrW-1:0] LastAddr = AddrW'(OAMObjects - 1);
    localparam logic [CntW-1:0]  MaxCnt   = CntW'(MaxPerLine);
    localparam logic [9:0]       HeightY  = 10'(SpriteHeight);
    localparam logic [3:0]       RowMax   = 4'(SpriteHeight - 1);

`ifdef SPRITE_OVERFLOW_EN
    localparam bit EarlyExit = 1'b0;
`else
    localparam bit EarlyExit = 1'b1;
`endif

    eval_state_e     state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [9:0]      line_q, line_d;
    logic [CntW-1:0] back_cnt_q, back_cnt_d;
    logic [CntW-1:0] front_cnt_q, front_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    oam_entry_t      entry;
    logic [9:0]      dy;
    logic            hit;
    logic            back_full;
    logic            wr_en;
    logic            swap;
    sprite_slot_t    wr_slot;
    sprite_slot_t    rd_slot;

    // Hit test and slot formatting for the entry currently on the OAM bus.
    always_comb begin
        entry             = decode_entry(oam_data);
        dy                = line_q - entry.y;
        hit               = entry.enable && (dy < HeightY);
        back_full         = (back_cnt_q == MaxCnt);
        wr_slot.prio      = entry.prio;
        wr_slot.xflip     = entry.xflip;
        wr_slot.row       = entry.yflip ? (RowMax - dy[3:0]) : dy[3:0];
        wr_slot.x         = entry.x;
        wr_slot.spriteref = entry.spriteref;
    end

    // Scan sequencing; line_start in any state (re)starts a scan.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_d      = line_q;
        back_cnt_d  = back_cnt_q;
        front_cnt_d = front_cnt_q;
        wr_en       = 1'b0;
        swap        = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StScan: begin
                if (!line_start) begin
                    if (hit && !back_full) begin
                        wr_en      = 1'b1;
                        back_cnt_d = back_cnt_q + CntW'(1);
                    end
                    if ((addr_q == LastAddr) ||
                        (EarlyExit && hit && (back_cnt_q == MaxCnt - CntW'(1)))) begin
                        state_d = StFinish;
                    end else begin
                        addr_d = addr_q + AddrW'(1);
                    end
                end
            end
            StFinish: begin
                swap        = 1'b1;
                front_cnt_d = back_cnt_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (line_start) begin
            state_d    = StScan;
            line_d     = line_y;
            addr_d     = '0;
            back_cnt_d = '0;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StFinish);
    end

    // FSM state, counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            line_q      <= '0;
            back_cnt_q  <= '0;
            front_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            back_cnt_q  <= back_cnt_d;
            front_cnt_q <= front_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SPRITE_OVERFLOW_EN
    logic back_ovf_q, back_ovf_d;
    logic ovf_q, ovf_d;

    // Remember hits dropped for lack of slots; publish with the list swap.
    always_comb begin
        back_ovf_d = back_ovf_q;
        ovf_d      = ovf_q;
        if ((state_q == StScan) && hit && back_full) begin
            back_ovf_d = 1'b1;
        end
        if (swap) begin
            ovf_d = back_ovf_q;
        end
        if (line_start) begin
            back_ovf_d = 1'b0;
        end
    end

    // Overflow flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            back_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            back_ovf_q <= back_ovf_d;
            ovf_q      <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    sprite_slot_bank #(
        .Depth (MaxPerLine)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (back_cnt_q[IdxW-1:0]),
        .wr_data (wr_slot),
        .swap    (swap),
        .rd_idx  (slot_sel),
        .rd_data (rd_slot)
    );

    assign oam_addr   = addr_q;
    assign slot_data  = rd_slot;
    assign slot_count = front_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Scoreboard bench for sprite_line_evaluator: stimulus pushes expected line results
// computed from an OAM model; a monitor pops and checks them on each done pulse.
module tb_sprite_line_evaluator;

    localparam int NObj  = 64;
    localparam int NSlot = 8;
`ifdef SPRITE_OVERFLOW_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [9:0]  line_y;
    logic [5:0]  oam_addr;
    logic [31:0] oam_data;
    logic [2:0]  slot_sel;
    logic [23:0] slot_data;
    logic [3:0]  slot_count;
    logic        busy;
    logic        done;
    logic        overflow;

    logic [31:0] oam_mem [NObj];
    assign oam_data = oam_mem[oam_addr];

    sprite_line_evaluator dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .line_y     (line_y),
        .oam_addr   (oam_addr),
        .oam_data   (oam_data),
        .slot_sel   (slot_sel),
        .slot_data  (slot_data),
        .slot_count (slot_count),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        int          lat;
        int          cnt;
        bit          ovf;
        logic [23:0] slot [NSlot];
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] make_entry(input bit en, input bit yf, input bit xf,
                                               input bit pr, input int y, input int x,
                                               input logic [7:0] rf);
        logic [9:0] y10;
        logic [9:0] x10;
        y10 = 10'(y);
        x10 = 10'(x);
        return {en, yf, xf, pr, y10, x10, rf};
    endfunction

    // Reference: list of enabled sprites covering the line, in OAM order.
    function automatic exp_t model(input int ly);
        exp_t e;
        int   n;
        n     = 0;
        e.t   = 0;
        e.lat = NObj + 1;
        for (int s = 0; s < NSlot; s++) e.slot[s] = '0;
        for (int i = 0; i < NObj; i++) begin
            logic [31:0] w;
            logic [3:0]  r4;
            int          dy;
            w  = oam_mem[i];
            dy = (ly - int'(w[27:18]) + 1024) % 1024;
            if (w[31] && dy < 16) begin
                r4 = w[30] ? 4'(15 - dy) : 4'(dy);
                if (n < NSlot) e.slot[n] = {w[28], w[29], r4, w[17:8], w[7:0]};
                n++;
                if (!OvfEn && n == NSlot) begin
                    e.lat = i + 2;
                    break;
                end
            end
        end
        e.cnt = (n > NSlot) ? NSlot : n;
        e.ovf = OvfEn && (n > NSlot);
        return e;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < NObj; i++) oam_mem[i] = '0;
    endtask

    // Called at a negedge; returns at the negedge of the first scan cycle.
    task automatic start_line(input int ly, input bit push);
        exp_t e;
        e          = model(ly);
        e.t        = cyc;
        line_y     = 10'(ly);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("busy_in_scan", busy, 1);
        if (push) sbq.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sbq.size() != 0 || busy === 1'b1 || mon_busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: pending %0d results, required 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: on each done, check timing, then the swapped-in list one cycle later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 required no done (cycle %0d)",
                             cyc);
                end else begin
                    mon_busy = 1'b1;
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.t + e.lat);
                    @(negedge clk);
                    chk("slot_count", slot_count, e.cnt);
                    chk("overflow", overflow, e.ovf);
                    for (int i = 0; i < e.cnt; i++) begin
                        slot_sel = 3'(i);
                        #1;
                        chk("slot_data", slot_data, e.slot[i]);
                    end
                    slot_sel = '0;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, pending %0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [23:0] seen;
        bit          stable;
        reset      = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        slot_sel   = '0;
        clear_oam();
        repeat (2) @(negedge clk);
        chk("rst_slot_count", slot_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_oam_addr", oam_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single hit, row 10
        oam_mem[5] = make_entry(1, 0, 0, 0, 90, 300, 8'h2A);
        start_line(100, 1);
        wait_idle();
        chk("single_hit_slot0", slot_data, {1'b0, 1'b0, 4'd10, 10'd300, 8'h2A});
        chk("single_hit_count", slot_count, 1);

        // yflip: row 5; front slot 0 must hold the previous line's entry until swap
        oam_mem[5] = make_entry(1, 1, 0, 0, 90, 300, 8'h2A);
        start_line(100, 1);
        stable = 1'b1;
        seen   = slot_data;
        for (int k = 0; k < 65; k++) begin
            if (stable) begin
                seen = slot_data;
                if (slot_data !== {1'b0, 1'b0, 4'd10, 10'd300, 8'h2A}) stable = 1'b0;
            end
            @(negedge clk);
        end
        chk("front_hold_slot0", seen, {1'b0, 1'b0, 4'd10, 10'd300, 8'h2A});
        wait_idle();
        chk("yflip_slot0", slot_data, {1'b0, 1'b0, 4'd5, 10'd300, 8'h2A});

        // Misses: below the line, then disabled
        oam_mem[5] = make_entry(1, 0, 0, 0, 110, 300, 8'h2A);
        start_line(100, 1);
        wait_idle();
        oam_mem[5] = make_entry(0, 0, 0, 0, 90, 300, 8'h2A);
        start_line(100, 1);
        wait_idle();
        chk("disabled_count", slot_count, 0);

        // Ten hits at indices 0..9
        clear_oam();
        for (int i = 0; i < 10; i++) oam_mem[i] = make_entry(1, 0, i[0], 1, 50 - i, 10 * i, 8'(i));
        start_line(50, 1);
        wait_idle();
        chk("ten_hits_overflow", overflow, OvfEn);
        chk("ten_hits_count", slot_count, 8);

        // Restart mid-scan with a different line; only the second line completes
        clear_oam();
        for (int i = 0; i < 3; i++) oam_mem[i] = make_entry(1, 0, 0, 0, 48, i, 8'(i));
        for (int i = 10; i < 14; i++) oam_mem[i] = make_entry(1, 1, 1, 0, 190, i, 8'(i));
        start_line(50, 0);
        repeat (19) @(negedge clk);
        start_line(200, 1);
        wait_idle();

        // Reset mid-scan: no done, front list empty
        start_line(200, 0);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_slot_count", slot_count, 0);
        chk("midreset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        start_line(200, 1);
        wait_idle();

        // Randomized lines with varying density, including wrap near line 0
        for (int r = 0; r < 24; r++) begin
            int ly;
            int dens;
            ly   = int'($urandom_range(0, 1023));
            dens = int'($urandom_range(1, 4));
            for (int i = 0; i < NObj; i++) begin
                logic [31:0] w;
                int          offs;
                w         = $urandom;
                offs      = int'($urandom_range(0, 23)) - 4;
                w[27:18]  = 10'(ly - offs);
                w[31]     = (int'($urandom_range(0, 3)) < dens);
                oam_mem[i] = w;
            end
            start_line(ly, 1);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
